// File: rtl/bp_update_scheduler.sv
// Arbitrates the branch predictor's single index port between fetch lookups
// (priority) and a FIFO of execute-stage updates drained on idle or forced cycles.
module bp_update_scheduler #(
  parameter int IDX_W    = 8,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lk_valid,
  input  logic [IDX_W-1:0]         lk_index,
  output logic                     lk_ready,
  output logic                     lk_taken,
  input  logic                     up_valid,
  input  logic [IDX_W-1:0]         up_index,
  input  logic                     up_taken,
  output logic                     up_ready,
  output logic [IDX_W-1:0]         pred_index,
  output logic                     pred_update,
  output logic                     pred_actual_taken,
  input  logic                     pred_predict_taken,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic             tkn_mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_next;
  logic             enq;
  logic             deq;

  // Handshakes: a lookup is granted when lk_valid & lk_ready; an update is
  // accepted when up_valid & up_ready. Ready never depends on its own valid.
  always_comb begin
    lk_ready    = (state == NORMAL) & ~rst;
    up_ready    = (count < CW'(DEPTH));
    deq         = (count != '0) & ((state == FORCE) | ~lk_valid) & ~rst;
    enq         = up_valid & up_ready;
    pred_update = deq;
  end

  always_comb begin
    pred_index        = deq ? idx_mem[rd_ptr] : lk_index;
    pred_actual_taken = tkn_mem[rd_ptr];
    lk_taken          = pred_predict_taken;
    pending           = count;
    state_dbg         = (state == FORCE);
  end

  always_comb begin
    count_next = count + CW'(enq) - CW'(deq);
  end

  // Counts lookups that starved a non-empty queue; any drain restarts it.
  always_comb begin
    wait_next = wait_cnt;
    if (deq || (count == '0)) begin
      wait_next = '0;
    end else if (lk_valid && lk_ready && (wait_cnt < WW'(MAX_WAIT))) begin
      wait_next = wait_cnt + WW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: begin
        if ((count_next == CW'(DEPTH)) || (wait_next >= WW'(MAX_WAIT))) begin
          state_next = FORCE;
        end
      end
      FORCE: begin
        state_next = NORMAL;
      end
      default: begin
        state_next = NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      wait_cnt <= wait_next;
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage is not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      idx_mem[wr_ptr] <= up_index;
      tkn_mem[wr_ptr] <= up_taken;
    end
  end

  a_force_has_entry: assert property (@(posedge clk) disable iff (rst)
    (state == FORCE) |-> (count != '0));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));
  a_wait_bound: assert property (@(posedge clk) disable iff (rst)
    wait_cnt <= WW'(MAX_WAIT));

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_bp_update_scheduler;

  localparam int IDX_W    = 8;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int PEND_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              lk_valid;
  logic [IDX_W-1:0]  lk_index;
  logic              lk_ready;
  logic              lk_taken;
  logic              up_valid;
  logic [IDX_W-1:0]  up_index;
  logic              up_taken;
  logic              up_ready;
  logic [IDX_W-1:0]  pred_index;
  logic              pred_update;
  logic              pred_actual_taken;
  logic              pred_predict_taken;
  logic [PEND_W-1:0] pending;
  logic              state_dbg;

  int checks = 0;
  int errors = 0;

  logic [1:0] ptab  [256];
  logic [1:0] m_tab [256];
  logic [IDX_W:0] exp_q [$];
  logic m_force;
  int   m_wait;

  bp_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_ready(lk_ready), .lk_taken(lk_taken),
    .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_ready(up_ready),
    .pred_index(pred_index), .pred_update(pred_update),
    .pred_actual_taken(pred_actual_taken), .pred_predict_taken(pred_predict_taken),
    .pending(pending), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor table environment: 2-bit counters, combinational read.
  assign pred_predict_taken = ptab[pred_index][1];
  initial begin
    for (int i = 0; i < 256; i++) ptab[i] = 2'b01;
    forever begin
      @(posedge clk);
      if (pred_update === 1'b1) ptab[pred_index] = sat2(ptab[pred_index], pred_actual_taken);
    end
  end

  // Scoreboard: behavioural model advanced once per cycle at the negedge.
  initial begin
    int  sz;
    logic e_ready;
    logic e_upd;
    logic [IDX_W:0] head;
    for (int i = 0; i < 256; i++) m_tab[i] = 2'b01;
    m_force = 1'b0;
    m_wait  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_pred_update", pred_update, 0);
        chk("rst_lk_ready", lk_ready, 0);
        exp_q.delete();
        m_force = 1'b0;
        m_wait  = 0;
      end else begin
        sz      = exp_q.size();
        e_ready = !m_force;
        e_upd   = (sz > 0) && (m_force || !lk_valid);
        chk("m_lk_ready", lk_ready, e_ready);
        chk("m_up_ready", up_ready, sz < DEPTH);
        chk("m_pending", pending, sz);
        chk("m_pred_update", pred_update, e_upd);
        if (lk_valid && e_ready) chk("m_lk_taken", lk_taken, m_tab[lk_index][1]);
        if (e_upd) begin
          head = exp_q.pop_front();
          chk("m_pred_index_upd", pred_index, head[IDX_W:1]);
          chk("m_pred_actual", pred_actual_taken, head[0]);
          m_tab[head[IDX_W:1]] = sat2(m_tab[head[IDX_W:1]], head[0]);
        end else begin
          chk("m_pred_index_lk", pred_index, lk_index);
        end
        if (up_valid && sz < DEPTH) exp_q.push_back({up_index, up_taken});
        if (e_upd || sz == 0) m_wait = 0;
        else if (lk_valid && e_ready && m_wait < MAX_WAIT) m_wait++;
        m_force = !m_force && (exp_q.size() == DEPTH || m_wait >= MAX_WAIT);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [IDX_W-1:0] li,
                       input logic uv, input logic [IDX_W-1:0] ui, input logic ut);
    lk_valid = lv;
    lk_index = li;
    up_valid = uv;
    up_index = ui;
    up_taken = ut;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    while (pending != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", pending, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  grants;
    logic done;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single update drains on the first lookup-free cycle.
    drive(1'b0, '0, 1'b1, 8'h10, 1'b1);
    @(negedge clk);
    chk("reset_pending", pending, 0);
    chk("reset_lk_ready", lk_ready, 1);
    chk("reset_up_ready", up_ready, 1);
    chk("reset_pred_update", pred_update, 0);
    chk("reset_state", state_dbg, 0);
    step(); drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t1_pending", pending, 1);
    chk("t1_pred_update", pred_update, 1);
    chk("t1_pred_index", pred_index, 8'h10);
    chk("t1_actual", pred_actual_taken, 1);
    step();
    @(negedge clk);
    chk("t1_pending_after", pending, 0);
    step(); drive(1'b1, 8'h10, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t1_lookup_taken", lk_taken, 1);

    // Continuous lookups starve one update until the forced drain.
    step(); drive(1'b1, 8'h20, 1'b1, 8'h30, 1'b0);
    step(); drive(1'b1, 8'h20, 1'b0, '0, 1'b0);
    grants = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (lk_ready) grants++;
      else begin
        done = 1'b1;
        chk("t2_force_update", pred_update, 1);
        chk("t2_force_pending", pending, 1);
      end
      step();
    end
    chk("t2_grants", grants, MAX_WAIT);
    @(negedge clk);
    chk("t2_ready_again", lk_ready, 1);
    chk("t2_pending_after", pending, 0);

    // Full queue forces a drain on the next cycle.
    for (int i = 0; i < DEPTH; i++) begin
      step(); drive(1'b1, 8'h21, 1'b1, 8'(8'h60 + i), i[0]);
    end
    step(); drive(1'b1, 8'h21, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t3_full_pending", pending, DEPTH);
    chk("t3_full_up_ready", up_ready, 0);
    chk("t3_force_lk_ready", lk_ready, 0);
    chk("t3_force_update", pred_update, 1);
    step();
    @(negedge clk);
    chk("t3_pending_after", pending, DEPTH - 1);
    chk("t3_up_ready_after", up_ready, 1);
    chk("t3_lk_ready_after", lk_ready, 1);
    step(); drain_all();

    // Streaming enqueue+drain keeps occupancy and order across pointer wrap.
    step(); drive(1'b1, 8'h22, 1'b1, 8'h70, 1'b1);
    step(); drive(1'b1, 8'h22, 1'b1, 8'h71, 1'b0);
    for (int i = 2; i < 10; i++) begin
      step(); drive(1'b0, '0, 1'b1, 8'(8'h70 + i), i[0]);
      @(negedge clk);
      chk("t4_pending", pending, 2);
      chk("t4_order", pred_index, 8'(8'h70 + i - 2));
    end
    step(); drain_all();

    // Two taken updates to one index; lookups before the drain see the old value.
    step(); drive(1'b1, 8'h05, 1'b1, 8'h05, 1'b1);
    @(negedge clk);
    chk("t5_pre_lookup0", lk_taken, 0);
    step(); drive(1'b1, 8'h05, 1'b1, 8'h05, 1'b1);
    @(negedge clk);
    chk("t5_pre_lookup1", lk_taken, 0);
    step(); drain_all();
    step(); drive(1'b1, 8'h05, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t5_post_lookup", lk_taken, 1);
    chk("t5_table_entry", ptab[5], 2'b11);

    // Reset asserted during a forced drain with three entries queued.
    for (int i = 0; i < 3; i++) begin
      step(); drive(1'b1, 8'h23, 1'b1, 8'(8'h80 + i), 1'b1);
    end
    step(); drive(1'b1, 8'h23, 1'b0, '0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!lk_ready) done = 1'b1;
      else step();
    end
    chk("t6_force_reached", done, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_pending", pending, 3);
    chk("t6_rst_no_update", pred_update, 0);
    step(); rst = 1'b0; drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t6_after_pending", pending, 0);
    chk("t6_after_lk_ready", lk_ready, 1);
    chk("t6_after_state", state_dbg, 0);
    chk("t6_after_update", pred_update, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 75, 8'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 45, 8'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end
    step(); rst = 1'b0; drain_all();
    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
